right_shift_multiplier: RTL and testbench
=========================================

# right_shift_multiplier

Sequential unsigned shift-and-add multiplier using a right-shifting accumulator/multiplier register pair. It consumes one multiplier bit per clock and returns the full double-width product after WIDTH iterations. It sits in the datapath labs as a small iterative arithmetic unit, chosen for area over latency.

## Interface
Parameters:
- WIDTH, default 6: operand width; the product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state.
- load  input  1  start pulse; samples a and b at the rising edge.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- product  output  2*WIDTH  registered result a*b.
- done  output  1  present only with RIGHT_MUL_DONE_EN (see Configuration).

## Operation
- Internal state: M (WIDTH, multiplicand), A (WIDTH+1, accumulator including carry), Q (WIDTH, multiplier/low product), cnt (ceil(log2(WIDTH+1)) bits), busy.
- States: IDLE (busy=0), RUN (busy=1).
- load=1 at an edge, in any state: M<=a, Q<=b, A<=0, cnt<=WIDTH, busy<=1. A new load mid-operation abandons the current multiply and restarts. If load is held high, the block reloads every edge and does not advance.
- RUN, load=0, each edge: if Q[0]=1 then A<=A+M (carry kept in A[WIDTH]); then {A,Q} is shifted right one bit with 0 into the MSB; cnt<=cnt-1.
- Final iteration (cnt==1): product<=low 2*WIDTH bits of the shifted {A,Q}; busy<=0; return to IDLE.
- IDLE, load=0: hold all state; product holds the last result.
- Arithmetic is unsigned. The result never exceeds 2*WIDTH bits, so there is no overflow.

## Timing
- Reset asserted (reset=0): product=0, A=0, Q=0, M=0, cnt=0, busy=0, done=0, immediately and asynchronously. Deassertion is taken at the next clock edge.
- Latency: load sampled at edge N; iterations occur on edges N+1 through N+WIDTH; product is valid after edge N+WIDTH (6 cycles at default).
- product changes only on the completing edge, or on reset. It does not change on load and shows no intermediate values.
- Reset mid-operation aborts the multiply; product returns to 0.
- Throughput: a new load may be issued on the completing edge N+WIDTH or later. A load issued earlier restarts the multiply.

## Configuration
- RIGHT_MUL_DONE_EN defined: adds output done, a one-cycle registered pulse high for exactly the cycle after the completing edge. done is 0 on reset and 0 when load coincides with completion.
- RIGHT_MUL_DONE_EN undefined: no done port. Callers count WIDTH cycles after load.

## Structure
- Shared package: the state enum (IDLE, RUN), the default WIDTH constant, and the count-width helper function.
- One natural sub-module, right_mul_addshift: combinational WIDTH-bit add of M into A, conditional on Q[0], followed by the 1-bit right shift of {A,Q}. The top module holds the registers, counter and control.

## Test plan
- Reset low with a=5, b=6 -> product=0; release reset, pulse load one cycle -> after 6 edges product=12'h01E (30).
- a=63, b=63 -> product=12'hF81 (3969), including carry out of the accumulator.
- a=0, b=45 and a=45, b=0 -> product=0. Then a=1, b=63 -> 12'h03F.
- Load 7x9; at edge 3, load 10x10 -> product never shows 63; product=100 six edges after the second load.
- Assert reset at edge 4 of 5x6 -> product=0 immediately, and remains 0 with no load. With RIGHT_MUL_DONE_EN defined, done stays low.
- Back-to-back: load 3x4, then reload 2x2 on the completing edge -> product=12, then 4 six edges later. done pulses once per completed multiply.

Source files
------------

// File: rtl/right_shift_multiplier_pkg.sv
// Shared types and constants for the right-shift shift-and-add multiplier.
package right_shift_multiplier_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 6;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/right_mul_addshift.sv
// One multiply iteration: conditionally add M into A, then shift {A,Q} right by one.
module right_mul_addshift #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum_s;

    // Add the multiplicand only when the current multiplier bit is set.
    always_comb begin
        sum_s = acc;
        if (q[0]) begin
            sum_s = acc + {1'b0, m};
        end else begin
            sum_s = acc;
        end
    end

    // The carry lands in acc[WIDTH] before the shift and moves down into the low word.
    assign acc_next = {1'b0, sum_s[WIDTH:1]};
    assign q_next   = {sum_s[0], q[WIDTH-1:1]};

endmodule

// File: rtl/right_shift_multiplier.sv
// Iterative unsigned multiplier, one multiplier bit per clock, 2*WIDTH-bit registered product.
// Optional done pulse enabled by defining RIGHT_MUL_DONE_EN.
module right_shift_multiplier
    import right_shift_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
`ifdef RIGHT_MUL_DONE_EN
    ,
    output logic               done
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   m_r, m_s;
    logic [WIDTH:0]     a_r, a_s;
    logic [WIDTH-1:0]   q_r, q_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [2*WIDTH-1:0] product_r, product_s;
    logic [WIDTH:0]     a_step_s;
    logic [WIDTH-1:0]   q_step_s;
    logic               last_s;

    right_mul_addshift #(
        .WIDTH (WIDTH)
    ) u_addshift (
        .m        (m_r),
        .acc      (a_r),
        .q        (q_r),
        .acc_next (a_step_s),
        .q_next   (q_step_s)
    );

    assign last_s = (state_r == RUN) && (cnt_r == CNT_ONE);

    // Next-state and datapath control; load always wins over iteration.
    always_comb begin
        state_s   = state_r;
        m_s       = m_r;
        a_s       = a_r;
        q_s       = q_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        case (state_r)
            IDLE: begin
                if (load) begin
                    m_s     = a;
                    q_s     = b;
                    a_s     = {(WIDTH+1){1'b0}};
                    cnt_s   = CNT_INIT;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // The finishing result is captured even if a new load arrives on the same edge.
                if (last_s) begin
                    product_s = {a_step_s[WIDTH-1:0], q_step_s};
                end else begin
                    product_s = product_r;
                end
                if (load) begin
                    m_s     = a;
                    q_s     = b;
                    a_s     = {(WIDTH+1){1'b0}};
                    cnt_s   = CNT_INIT;
                    state_s = RUN;
                end else begin
                    a_s   = a_step_s;
                    q_s   = q_step_s;
                    cnt_s = cnt_r - CNT_ONE;
                    if (last_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            m_r       <= {WIDTH{1'b0}};
            a_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            state_r   <= state_s;
            m_r       <= m_s;
            a_r       <= a_s;
            q_r       <= q_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
        end
    end

    assign product = product_r;

`ifdef RIGHT_MUL_DONE_EN
    logic done_r;

    // Completion pulse, suppressed when a reload coincides with the finishing edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s && !load;
        end
    end

    assign done = done_r;
`endif

endmodule

// File: tb/tb_right_shift_multiplier.sv
// Scoreboard bench for right_shift_multiplier; checks done too when RIGHT_MUL_DONE_EN is defined.
module tb_right_shift_multiplier;

    localparam int W = 6;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           load  = 1'b0;
    logic [W-1:0]   a     = '0;
    logic [W-1:0]   b     = '0;
    logic [2*W-1:0] product;
`ifdef RIGHT_MUL_DONE_EN
    logic           done;
`endif

    int             checks = 0;
    int             errors = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] last_prod = '0;

    right_shift_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .a       (a),
        .b       (b),
        .product (product)
`ifdef RIGHT_MUL_DONE_EN
        ,
        .done    (done)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic start(input logic [W-1:0] ia, input logic [W-1:0] ib);
        logic [2*W-1:0] exp;
        @(negedge clk);
        a    = ia;
        b    = ib;
        load = 1'b1;
        exp  = {{W{1'b0}}, ia} * {{W{1'b0}}, ib};
        sb.push_back(exp);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called at the negedge after the load edge; checks hold, then the result.
    task automatic finish_wait(input string name);
        logic [2*W-1:0] exp;
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            checks++;
            if (product !== last_prod) begin
                $display("FAIL %s_hold cycle %0d: product=%h expected %h", name, i, product, last_prod);
                errors++;
            end
`ifdef RIGHT_MUL_DONE_EN
            checks++;
            if (done !== 1'b0) begin
                $display("FAIL %s_done_early cycle %0d: done=%b expected 0", name, i, done);
                errors++;
            end
`endif
        end
        @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (product !== exp) begin
            $display("FAIL %s_result: product=%h expected %h", name, product, exp);
            errors++;
        end
`ifdef RIGHT_MUL_DONE_EN
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL %s_done: done=%b expected 1", name, done);
            errors++;
        end
`endif
        last_prod = exp;
    endtask

    task automatic test_reset();
        a = 6'd5;
        b = 6'd6;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (product !== 12'h000) begin
            $display("FAIL reset_async: product=%h expected 000", product);
            errors++;
        end
        load = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (product !== 12'h000) begin
            $display("FAIL reset_held: product=%h expected 000", product);
            errors++;
        end
`ifdef RIGHT_MUL_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL reset_done: done=%b expected 0", done);
            errors++;
        end
`endif
        load  = 1'b0;
        reset = 1'b1;
        last_prod = 12'h000;
    endtask

    task automatic test_basic();
        start(6'd5, 6'd6);   finish_wait("mul_5x6");
        start(6'd63, 6'd63); finish_wait("mul_63x63");
        start(6'd0, 6'd45);  finish_wait("mul_0x45");
        start(6'd45, 6'd0);  finish_wait("mul_45x0");
        start(6'd1, 6'd63);  finish_wait("mul_1x63");
        for (int i = 0; i < 4; i++) begin
            start(6'($urandom_range(63)), 6'($urandom_range(63)));
            finish_wait("mul_random");
        end
    endtask

    task automatic test_restart();
        start(6'd7, 6'd9);
        @(negedge clk);
        checks++;
        if (product !== last_prod) begin
            $display("FAIL restart_hold: product=%h expected %h", product, last_prod);
            errors++;
        end
        void'(sb.pop_back());
        start(6'd10, 6'd10);
        finish_wait("restart_10x10");
    endtask

    task automatic test_reset_mid();
        start(6'd5, 6'd6);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (product !== 12'h000) begin
            $display("FAIL reset_mid_async: product=%h expected 000", product);
            errors++;
        end
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b1;
        last_prod = 12'h000;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            checks++;
            if (product !== 12'h000) begin
                $display("FAIL reset_mid_hold cycle %0d: product=%h expected 000", i, product);
                errors++;
            end
`ifdef RIGHT_MUL_DONE_EN
            checks++;
            if (done !== 1'b0) begin
                $display("FAIL reset_mid_done cycle %0d: done=%b expected 0", i, done);
                errors++;
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp;
        start(6'd3, 6'd4);
        repeat (W - 1) @(negedge clk);
        a    = 6'd2;
        b    = 6'd2;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        exp  = sb.pop_front();
        checks++;
        if (product !== exp) begin
            $display("FAIL b2b_first: product=%h expected %h", product, exp);
            errors++;
        end
`ifdef RIGHT_MUL_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL b2b_done_coincide: done=%b expected 0", done);
            errors++;
        end
`endif
        last_prod = exp;
        sb.push_back(12'd4);
        finish_wait("b2b_second");
        @(negedge clk);
        checks++;
        if (product !== 12'd4) begin
            $display("FAIL b2b_idle_hold: product=%h expected 004", product);
            errors++;
        end
`ifdef RIGHT_MUL_DONE_EN
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL b2b_done_width: done=%b expected 0", done);
            errors++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
